// File: rtl/port_tx_gmii_monitor_pkg.sv
// port_tx_mon_pkg: shared FSM states, framing constants and CRC-32 helpers for the GMII TX monitor
package port_tx_mon_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_DATA, ST_DROP} state_t;
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;
    localparam int MAX_PREAMBLE = 7;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) c = (c >> 1) ^ ((c[0] ^ d[i]) ? CRC_POLY : 32'h0);
        return c;
    endfunction

    // The shift-right engine holds the residue bit-reversed relative to CRC_RESIDUE
    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction
endpackage

// File: rtl/port_tx_gmii_monitor_if.sv
// port_tx_gmii_monitor_if: GMII TX tap inputs and AXI-Stream frame output of the monitor
interface port_tx_gmii_monitor_if;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       m_axis_tlast;
    logic       m_axis_tuser;
    modport master (output gmii_txd, gmii_tx_en, gmii_tx_er, m_axis_tready,
                    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser);
    modport slave  (input  gmii_txd, gmii_tx_en, gmii_tx_er, m_axis_tready,
                    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser);
endinterface

// File: rtl/port_tx_mon_pkt_fifo.sv
// port_tx_mon_pkt_fifo: store-and-forward frame buffer of {last, err, data} with commit/rewind and registered AXIS output
module port_tx_mon_pkt_fifo #(
    parameter int DEPTH = 2048
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_wr_en,
    input  logic [9:0] i_wr_data,
    input  logic       i_commit,
    input  logic       i_rewind,
    output logic       o_full,
    output logic [7:0] o_tdata,
    output logic       o_tvalid,
    output logic       o_tlast,
    output logic       o_tuser,
    input  logic       i_tready
);
    localparam int AW = $clog2(DEPTH);
    logic [9:0]  r_mem [DEPTH];
    logic [AW:0] r_wptr, r_cptr, r_rptr;
    logic        w_pop;

    assign o_full = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    // Reader only sees bytes below the commit pointer
    assign w_pop = (r_rptr != r_cptr) && (!o_tvalid || i_tready);

    always_ff @(posedge i_clk)
        if (i_wr_en) r_mem[r_wptr[AW-1:0]] <= i_wr_data;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr   <= '0;
            r_cptr   <= '0;
            r_rptr   <= '0;
            o_tdata  <= '0;
            o_tvalid <= 1'b0;
            o_tlast  <= 1'b0;
            o_tuser  <= 1'b0;
        end else begin
            if (i_rewind) r_wptr <= r_cptr;
            else if (i_wr_en) r_wptr <= r_wptr + (AW+1)'(1);
            if (i_commit) r_cptr <= r_wptr + (AW+1)'(i_wr_en);
            if (w_pop) begin
                {o_tlast, o_tuser, o_tdata} <= r_mem[r_rptr[AW-1:0]];
                o_tvalid <= 1'b1;
                r_rptr   <= r_rptr + (AW+1)'(1);
            end else if (i_tready) begin
                o_tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/port_tx_gmii_monitor.sv
// port_tx_gmii_monitor: GMII TX frame monitor feeding a store-and-forward AXI-Stream output.
// Define PORT_TX_MON_FCS_CHECK_EN to check the CRC-32 FCS and strip it from the output.
module port_tx_gmii_monitor
    import port_tx_mon_pkg::*;
#(
    parameter int FIFO_DEPTH    = 2048,
    parameter int MIN_FRAME_LEN = 64
) (
    input  logic        axi_aclk,
    input  logic        axi_aresetn,
    port_tx_gmii_monitor_if.slave bus,
    output logic [31:0] frame_cnt,
    output logic [31:0] err_cnt,
    output logic [31:0] drop_cnt
);
`ifdef PORT_TX_MON_FCS_CHECK_EN
    localparam int D = 5;
`else
    localparam int D = 1;
`endif
    localparam int LW = (D > 1) ? $clog2(D + 1) : 1;
    localparam int NW = $clog2(MIN_FRAME_LEN + 1);

    state_t        r_state;
    logic [2:0]    r_pre_cnt;
    logic [7:0]    r_line [D];
    logic [LW-1:0] r_lcnt;
    logic [NW-1:0] r_len;
    logic          r_err, r_fresh;
    logic          w_end, w_wr, w_full, w_ovf, w_commit, w_err_end, w_crc_bad;
    logic [LW-1:0] w_oidx;
    logic [9:0]    w_wdata;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return v + 32'(v != '1);
    endfunction

    // Delay line holds the newest D bytes; at frame end only its oldest byte survives
    assign w_oidx    = r_lcnt - LW'(1);
    assign w_end     = r_state == ST_DATA && !bus.gmii_tx_en && r_lcnt != '0;
    assign w_wr      = w_end || (r_state == ST_DATA && bus.gmii_tx_en && r_lcnt == LW'(D));
    assign w_ovf     = w_wr && w_full;
    assign w_commit  = w_end && !w_full;
    assign w_err_end = r_err || r_len < NW'(MIN_FRAME_LEN) || w_crc_bad;
    assign w_wdata   = w_end ? {1'b1, w_err_end, r_line[w_oidx]} : {2'b00, r_line[D-1]};

`ifdef PORT_TX_MON_FCS_CHECK_EN
    logic [31:0] r_crc;
    assign w_crc_bad = bitrev32(r_crc) != CRC_RESIDUE;
    always_ff @(posedge axi_aclk)
        if (!axi_aresetn || r_state != ST_DATA) r_crc <= CRC_INIT;
        else if (bus.gmii_tx_en) r_crc <= crc32_byte(r_crc, bus.gmii_txd);
`else
    assign w_crc_bad = 1'b0;
`endif

    always_ff @(posedge axi_aclk)
        if (r_state == ST_DATA && bus.gmii_tx_en) begin
            r_line[0] <= bus.gmii_txd;
            for (int i = 1; i < D; i++) r_line[i] <= r_line[i-1];
        end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            r_state   <= ST_IDLE;
            r_pre_cnt <= '0;
            r_lcnt    <= '0;
            r_len     <= '0;
            r_err     <= 1'b0;
            r_fresh   <= 1'b1;
            frame_cnt <= '0;
            err_cnt   <= '0;
            drop_cnt  <= '0;
        end else begin
            r_fresh   <= 1'b0;
            r_pre_cnt <= '0;
            case (r_state)
                ST_IDLE, ST_PREAMBLE:
                    if (!bus.gmii_tx_en) r_state <= ST_IDLE;
                    else if (r_fresh) r_state <= ST_DROP;
                    else if (bus.gmii_txd == SFD_BYTE) begin
                        r_state <= ST_DATA;
                        r_lcnt  <= '0;
                        r_len   <= '0;
                        r_err   <= 1'b0;
                    end else if (bus.gmii_txd == PREAMBLE_BYTE && r_pre_cnt < 3'(MAX_PREAMBLE)) begin
                        r_state   <= ST_PREAMBLE;
                        r_pre_cnt <= r_pre_cnt + 3'd1;
                    end else begin
                        r_state <= ST_DROP;
                        err_cnt <= sat_inc(err_cnt);
                    end
                ST_DATA:
                    if (w_ovf) begin
                        r_state  <= ST_DROP;
                        drop_cnt <= sat_inc(drop_cnt);
                    end else if (!bus.gmii_tx_en) begin
                        r_state <= ST_IDLE;
                        if (w_end) begin
                            frame_cnt <= sat_inc(frame_cnt);
                            if (w_err_end) err_cnt <= sat_inc(err_cnt);
                        end
                    end else begin
                        if (r_lcnt != LW'(D)) r_lcnt <= r_lcnt + LW'(1);
                        if (r_len != NW'(MIN_FRAME_LEN)) r_len <= r_len + NW'(1);
                        if (bus.gmii_tx_er) r_err <= 1'b1;
                    end
                default:
                    if (!bus.gmii_tx_en) r_state <= ST_IDLE;
            endcase
        end
    end

    port_tx_mon_pkt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk    (axi_aclk),
        .i_rst_n  (axi_aresetn),
        .i_wr_en  (w_wr && !w_full),
        .i_wr_data(w_wdata),
        .i_commit (w_commit),
        .i_rewind (w_ovf),
        .o_full   (w_full),
        .o_tdata  (bus.m_axis_tdata),
        .o_tvalid (bus.m_axis_tvalid),
        .o_tlast  (bus.m_axis_tlast),
        .o_tuser  (bus.m_axis_tuser),
        .i_tready (bus.m_axis_tready)
    );
endmodule

// File: doc/port_tx_gmii_monitor.md
PORT_TX_GMII_MONITOR -- requirements
Module: port_tx_gmii_monitor

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2048, frame-buffer depth in bytes (power of 2, min 128).
REQ-002 SHALL have parameter MIN_FRAME_LEN, default 64, minimum legal frame length in bytes including FCS.
REQ-003 SHALL have port axi_aclk  input  1  single clock; GMII TX and AXIS are both synchronous to it.
REQ-004 SHALL have port axi_aresetn  input  1  synchronous active-low reset.
REQ-005 SHALL have port gmii_txd  input  8  byte from the MAC TX path.
REQ-006 SHALL have port gmii_tx_en  input  1  frame-valid qualifier.
REQ-007 SHALL have port gmii_tx_er  input  1  MAC-signalled error.
REQ-008 SHALL have port m_axis_tdata  output  8  frame byte.
REQ-009 SHALL have port m_axis_tvalid  output  1  byte valid.
REQ-010 SHALL have port m_axis_tready  input  1  consumer ready.
REQ-011 SHALL have port m_axis_tlast  output  1  last byte of frame.
REQ-012 SHALL have port m_axis_tuser  output  1  frame error; meaningful only with tlast.
REQ-013 SHALL have ports frame_cnt, err_cnt, drop_cnt  output  32 each  committed-frame, errored-frame and dropped-frame counters.

Function
REQ-014 SHALL run FSM IDLE, PREAMBLE, DATA, DROP; IDLE->PREAMBLE on gmii_tx_en high.
REQ-015 PREAMBLE SHALL accept 0-7 bytes of 0x55 followed by 0xD5 and then go to DATA; any other byte, or more than 7 preambles, SHALL go to DROP and increment err_cnt.
REQ-016 DATA SHALL pass bytes through a delay line of depth D (D per REQ-027); a byte leaves the line into the buffer only when the line is full and a new byte arrives.
REQ-017 On gmii_tx_en falling in DATA, the oldest byte still in the line SHALL be written with last=1; the remaining D-1 bytes SHALL be discarded; the FSM SHALL return to IDLE.
REQ-018 The frame error flag SHALL be set by any gmii_tx_er while in DATA, by a length below MIN_FRAME_LEN, or by an FCS mismatch (REQ-027).
REQ-019 Store-and-forward: the write side SHALL keep a commit pointer, and the read side SHALL see only bytes up to the commit pointer.
REQ-020 If a write would overflow the buffer, the write pointer SHALL rewind to the commit pointer, the FSM SHALL enter DROP, and drop_cnt SHALL increment once.
REQ-021 DROP SHALL ignore input until gmii_tx_en low, then go to IDLE.
REQ-022 At frame end: commit, frame_cnt+1, and err_cnt+1 if the error flag is set, all in the same cycle.
REQ-023 An overflow in the end-of-frame cycle SHALL drop the frame; no commit.
REQ-024 AXIS output SHALL be registered; tdata, tlast and tuser SHALL be stable while tvalid&&!tready; latency from commit to first tvalid is ≤3 cycles.
REQ-025 Counters SHALL saturate at 0xFFFFFFFF; pointers SHALL wrap modulo FIFO_DEPTH using one extra bit for full/empty.

Reset
REQ-026 On axi_aresetn low: FSM=IDLE, pointers=0, buffer empty, counters=0, tvalid=0, tlast=0, tuser=0, tdata=0; any partial frame is lost; if gmii_tx_en is high at reset release, the FSM SHALL enter DROP.

Configuration
REQ-027 With PORT_TX_MON_FCS_CHECK_EN defined: D=5, CRC-32 (IEEE 802.3, reflected, init 0xFFFFFFFF, residue 0xC704DD7B) over DATA bytes, mismatch sets the error flag, FCS stripped; without the macro: D=1, FCS forwarded as payload, no CRC logic, MIN_FRAME_LEN check unchanged.

Structure
REQ-028 Shared package port_tx_mon_pkg SHALL hold the FSM state enum, the preamble/SFD constants, the CRC polynomial/init/residue constants and the crc32_byte function.
REQ-029 The buffer SHALL be one sub-module, port_tx_mon_pkt_fifo: 10-bit entries {last, err, data}, with commit/rewind ports.

Verification
REQ-030 64-byte frame with 7×0x55, 0xD5, valid FCS, tready=1 (macro on) -> 60 bytes out, tlast on byte 60, tuser=0, frame_cnt=1.
REQ-031 Same frame with FCS last byte flipped -> 60 bytes out, tuser=1, err_cnt=1.
REQ-032 Preamble 0x55,0x55,0xAA -> nothing output, err_cnt=1, FSM in DROP until tx_en low.
REQ-033 FIFO_DEPTH=128, tready=0, frames of 100 then 100 bytes -> first committed, second dropped, drop_cnt=1; tready=1 -> exactly first frame emitted.
REQ-034 40-byte frame with valid FCS -> forwarded, tuser=1 (runt), err_cnt=1.
REQ-035 Reset asserted mid-frame and released with tx_en high -> no output, counters 0, next clean frame forwarded correctly.
